// File: rtl/gray_count_if.sv
// -----------------------------------------------------------------------------
// gray_count_if
// Bus bundle between the Gray-code counter and whatever consumes its value.
//
// Handshake: there is no valid/ready pair on this bus. enable is a level that
// the master holds for each clk edge it wants a count step on. gray_count
// (and wrap, when present) are registered and valid every cycle.
//
// Signals:
//   enable      master -> slave  count enable, sampled on clk rising edge
//   gray_count  slave  -> master registered Gray-code count, WIDTH bits
//   wrap        slave  -> master one-cycle pulse when the count rolls over
//                                (only when GRAY_COUNT_WRAP_EN is defined)
//
// Optional feature macro: GRAY_COUNT_WRAP_EN
// -----------------------------------------------------------------------------
interface gray_count_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic [WIDTH-1:0] gray_count;
`ifdef GRAY_COUNT_WRAP_EN
    logic             wrap;

    modport master (
        output enable,
        input  gray_count,
        input  wrap
    );

    modport slave (
        input  enable,
        output gray_count,
        output wrap
    );
`else
    modport master (
        output enable,
        input  gray_count
    );

    modport slave (
        input  enable,
        output gray_count
    );
`endif
endinterface

// File: rtl/gray_count.sv
// -----------------------------------------------------------------------------
// gray_count
// Free-running, enable-gated Gray-code up-counter. A binary count is kept
// internally; the Gray value is registered on the same edge as the binary
// step, so the output always equals bin ^ (bin >> 1) with no added latency
// and with no combinational path from any input to the output.
//
// Parameters:
//   WIDTH   counter width in bits, legal range 2..32 (default 8)
//
// Ports:
//   clk     rising-edge clock for all state
//   reset   asynchronous, active-high reset; clears all state immediately
//   bus     gray_count_if.slave
//             enable      count enable
//             gray_count  registered Gray-code count
//             wrap        one-cycle rollover pulse (GRAY_COUNT_WRAP_EN only)
//
// Optional feature macro: GRAY_COUNT_WRAP_EN
//   When defined, bus.wrap pulses high for one cycle on the enabled edge that
//   takes the binary count from all-ones to zero.
// -----------------------------------------------------------------------------
module gray_count #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    gray_count_if.slave bus
);

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gray_d;

    // The Gray flop is loaded from the *next* binary value so that the
    // registered output tracks bin_q exactly on every edge.
    always_comb begin
        bin_d = bin_q;
        if (bus.enable) begin
            bin_d = bin_q + 1'b1;
        end
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
        end
    end

    assign bus.gray_count = gray_q;

`ifdef GRAY_COUNT_WRAP_EN
    logic wrap_q;
    logic wrap_d;

    // Rollover is an enabled step out of all-ones; with enable low the pulse
    // drops back to 0 on the next edge.
    always_comb begin
        wrap_d = bus.enable && (bin_q == {WIDTH{1'b1}});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign bus.wrap = wrap_q;
`endif

endmodule

// File: tb/tb_gray_count.sv
module tb_gray_count;

    localparam int WIDTH = 8;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    gray_count_if #(.WIDTH(WIDTH)) bus ();

    gray_count #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change on the falling edge; outputs are sampled on the falling
    // edge after each rising edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_wrap(input string tag, input logic exp);
`ifdef GRAY_COUNT_WRAP_EN
        check_val(tag, {31'd0, bus.wrap}, {31'd0, exp});
`else
        if (exp === 1'bx) check_val(tag, 32'd0, 32'd1);
`endif
    endtask

    logic [WIDTH-1:0] prev_gray;
    logic [WIDTH-1:0] bin_m;
    logic [WIDTH-1:0] gray_m;

    initial begin
        reset      = 1'b1;
        bus.enable = 1'b0;
        step();
        step();

        // Reset state
        check_val("reset_gray", bus.gray_count, 8'h00);
        check_wrap("reset_wrap", 1'b0);

        // Count sequence: 8 enabled edges from reset
        reset      = 1'b0;
        bus.enable = 1'b1;
        exp_q = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04, 8'h0C};
        while (exp_q.size() > 0) begin
            step();
            check_val("count_seq", bus.gray_count, exp_q.pop_front());
        end

        // Asynchronous reset mid-count at 0x0C, between clk edges
        #1 reset = 1'b1;
        #1 check_val("async_reset_now", bus.gray_count, 8'h00);
        step();
        check_val("reset_hold_en1_a", bus.gray_count, 8'h00);
        step();
        check_val("reset_hold_en1_b", bus.gray_count, 8'h00);
        reset = 1'b0;
        #1 check_val("after_release", bus.gray_count, 8'h00);
        step();
        check_val("restart_1", bus.gray_count, 8'h01);
        step();
        check_val("restart_2", bus.gray_count, 8'h03);

        // Hold at 0x06 for 5 edges, then re-enable
        step();
        check_val("to_hold_a", bus.gray_count, 8'h02);
        step();
        check_val("to_hold_b", bus.gray_count, 8'h06);
        bus.enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("hold", bus.gray_count, 8'h06);
            check_wrap("hold_wrap", 1'b0);
        end
        bus.enable = 1'b1;
        step();
        check_val("reenable", bus.gray_count, 8'h07);

        // Single-bit property and wrap over 300 steps from reset
        bus.enable = 1'b0;
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        step();
        check_val("reset_before_run", bus.gray_count, 8'h00);
        bus.enable = 1'b1;
        prev_gray  = 8'h00;
        bin_m      = 8'h00;
        for (int k = 1; k <= 300; k++) begin
            step();
            bin_m  = bin_m + 8'd1;
            gray_m = bin_m ^ (bin_m >> 1);
            check_val("run_value", bus.gray_count, gray_m);
            check_val("run_hamming", $countones(bus.gray_count ^ prev_gray), 1);
            prev_gray = bus.gray_count;
            if (k == 255) begin
                check_val("wrap_pre", bus.gray_count, 8'h80);
                check_wrap("wrap_pre_flag", 1'b0);
            end else if (k == 256) begin
                check_val("wrap_zero", bus.gray_count, 8'h00);
                check_wrap("wrap_flag", 1'b1);
            end else if (k == 257) begin
                check_val("wrap_post", bus.gray_count, 8'h01);
                check_wrap("wrap_post_flag", 1'b0);
            end
        end

        // enable and reset together: reset wins
        reset = 1'b1;
        step();
        check_val("reset_wins", bus.gray_count, 8'h00);
        check_wrap("reset_wins_wrap", 1'b0);
        reset = 1'b0;
        step();
        check_val("final_step", bus.gray_count, 8'h01);

        // ---------------- final report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
